systolic_skew_feeder: RTL
=========================

# systolic_skew_feeder

Upstream feeder for one edge of the systolic PE array. Accepts one wide beat per cycle holding LANES operands over a valid/ready handshake. Emits the operands onto LANES array-edge lanes with a diagonal skew: lane i is delayed by i cycles, so data meets its partner wavefront in the right PE. It also frames the stream into tiles of ACC beats and forces one idle slot after each tile. In that slot each PE's accumulator clears (the PE drops any product that arrives in its clear cycle).

## Interface
- DBITS, 16: operand width; must match the PE array.
- LANES, 4: number of array-edge lanes (rows or columns fed).
- ACC, 3: beats per tile; must equal the PE ACC parameter; legal range 1..255.
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset. One clock; reset is synchronous and active-high.
- IN_DATA  input  LANES*DBITS  beat payload; lane i operand is IN_DATA[i*DBITS +: DBITS].
- IN_VALID  input  1  producer has a beat.
- IN_READY  output  1  feeder can accept this cycle.
- LANE_DATA  output  LANES*DBITS  skewed operands to array edge, lane i at [i*DBITS +: DBITS].
- LANE_VALID  output  LANES  per-lane valid to array edge (drives PE VALID_A or VALID_B).
- TILE_DONE  output  1  one-cycle pulse: last beat of a tile is on lane LANES-1.
- BUSY  output  1  tile in progress or any skew stage holds a valid beat.

## Operation
- Accept = IN_VALID && IN_READY. No downstream backpressure; the array never stalls.
- Skew pipeline: per lane i, a chain of i+1 registers carrying {data, valid, last}. Stage 0 of every lane loads on every cycle: the lane operand and valid=1 on accept; zero data and valid=0 otherwise. Each stage then shifts one per cycle. LANE_DATA/LANE_VALID[i] is the last stage of lane i.
- Invalid beats present LANE_DATA = 0 on that lane.
- last flag = 1 on the beat that completes a tile. It travels only in lane LANES-1's chain. TILE_DONE = valid && last at that chain's output.
- beat_cnt, width clog2(ACC)+1, counts accepted beats within the current tile.
- FSM:
  - IDLE: beat_cnt=0, IN_READY=1.
    - Accept with ACC==1 -> GAP.
    - Accept with ACC>1 -> FILL, beat_cnt=1.
  - FILL: IN_READY=1.
    - Accept with beat_cnt==ACC-1 -> GAP, beat_cnt=0.
    - Other accept -> beat_cnt+1.
    - No accept -> stay. Intra-tile bubbles are legal; the PE counts only valid beats.
  - GAP: IN_READY=0 for exactly one cycle -> IDLE.
- BUSY = (state != IDLE) || |valid bits in all skew stages.
- Tiles are back-to-back at best: ACC beats, 1 gap, ACC beats, ...

## Timing
- Reset (RST=1 at a clock edge) sets, the next cycle:
  - IN_READY=0 while RST is high.
  - LANE_DATA=0, LANE_VALID=0, TILE_DONE=0, BUSY=0.
  - State IDLE, beat_cnt=0, all skew stages cleared.
- IN_READY=1 the first cycle after RST is sampled low.
- Latency: a beat accepted at edge t appears on lane i during cycle t+1+i, i.e. lane 0 one cycle after accept.
- TILE_DONE is high during cycle t+LANES, where t is the edge accepting the tile's last beat.
- IN_READY depends only on state, never on IN_VALID (no combinational path).
- GAP is entered on the edge accepting beat ACC; IN_READY is low the following cycle only.
- Each lane's valid pattern is the accept pattern shifted by i+1. Each lane therefore sees the same 1-cycle hole per tile, aligned to the wavefront.
- Reset mid-tile discards partially received tiles and all in-flight skew data. No TILE_DONE fires for them. The new stream starts a fresh tile.
- Maximum throughput: ACC/(ACC+1) beats per cycle.

## Test plan
- Reset: hold RST 3 cycles with IN_VALID=1 -> IN_READY=0, all LANE_VALID=0, no accepts; IN_READY=1 the cycle after release.
- Skew, LANES=4, ACC=3: accept beat lanes {1,2,3,4} at edge t -> lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4; each LANE_VALID high exactly one cycle.
- Tile framing: IN_VALID held high for 8 cycles -> accepts at cycles 0,1,2,4,5,6; IN_READY low at 3 and 7; TILE_DONE at cycles 6 and 10.
- Intra-tile bubble: valid pattern 1,0,1,1 -> three accepts form one tile; GAP follows the third accept; lane3 valid pattern 1,0,1,1 shifted by 4.
- ACC=1 build: IN_VALID always high -> accept every other cycle, TILE_DONE after every beat.
- Mid-tile reset: RST asserted after 2 of 3 beats, 2 beats still in skew -> no LANE_VALID or TILE_DONE after reset. The next 3 accepts form a complete tile with TILE_DONE at accept3+4.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for one edge of the systolic PE array.
// Frames beats into ACC-beat tiles with a one-cycle gap after each tile.
module systolic_skew_feeder #(
  parameter int DBITS = 16,
  parameter int LANES = 4,
  parameter int ACC   = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [LANES*DBITS-1:0] IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [LANES*DBITS-1:0] LANE_DATA,
  output logic [LANES-1:0]       LANE_VALID,
  output logic                   TILE_DONE,
  output logic                   BUSY
);

  localparam int CW = $clog2(ACC) + 1;
  localparam logic [CW-1:0] ACC_M1 = CW'(ACC - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    GAP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;
  logic          tile_end;
  logic [LANES-1:0] lane_any;
  logic [LANES-1:0] last_q;

  // Ready comes from state only; reset masks it so nothing is taken
  assign IN_READY = !RST && (state_q != GAP);
  assign accept   = IN_VALID && IN_READY;

  // State and beat counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tile framing: count accepted beats, insert one gap per tile
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_end = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (cnt_q == ACC_M1) begin
            tile_end = 1'b1;
            state_d  = GAP;
            cnt_d    = '0;
          end else begin
            state_d = FILL;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-lane skew chains; lane i is i+1 registers deep
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DBITS-1:0] d_q [i+1];
    logic [i:0]       v_q;

    // Stage 0 loads every cycle, later stages shift
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int s = 0; s <= i; s++) begin
          d_q[s] <= '0;
        end
        v_q <= '0;
      end else begin
        d_q[0] <= accept ? IN_DATA[i*DBITS +: DBITS]
                         : '0;
        v_q[0] <= accept;
        for (int s = 1; s <= i; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end

    assign LANE_DATA[i*DBITS +: DBITS] = d_q[i];
    assign LANE_VALID[i] = v_q[i];
    assign lane_any[i]   = |v_q;
  end

  // Tile-end marker rides alongside the last lane only
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= '0;
    end else begin
      last_q <= {last_q[LANES-2:0], accept && tile_end};
    end
  end

  assign TILE_DONE = LANE_VALID[LANES-1] && last_q[LANES-1];
  assign BUSY      = (state_q != IDLE) || (|lane_any);

endmodule
